// File: rtl/calc_key_ctrl.sv
// calc_key_ctrl: button sync/debounce, mode toggles and operand
// capture feeding the 4-bit signed calculator's SW/KEY inputs.
module calc_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [7:0] SW,
  input  logic [3:0] KEY,
  output logic [7:0] SW_OUT,
  output logic [2:0] KEY_OUT,
  output logic       LOAD_PULSE,
  output logic [2:0] MODE_LED
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       kq1_q;
  logic [3:0]       kq2_q;
  logic [7:0]       swq1_q;
  logic [7:0]       swq2_q;
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press;
  logic [2:0]       mode_q;
  logic [7:0]       sw_out_q;
  logic             load_q;

  // two-flop synchronisers for raw buttons and switches
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      kq1_q  <= 4'hF;
      kq2_q  <= 4'hF;
      swq1_q <= 8'h00;
      swq2_q <= 8'h00;
    end else begin
      kq1_q  <= KEY;
      kq2_q  <= kq1_q;
      swq1_q <= SW;
      swq2_q <= swq1_q;
    end
  end

  // debounce next state; a press is stable falling 1->0
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (kq2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX)
          stable_d[i] = ~stable_q[i];
        else
          cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    press = stable_q & ~stable_d;
  end

  // debounce state registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      stable_q <= 4'hF;
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  // mode toggles, operand capture and load strobe
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_q   <= 3'b000;
      sw_out_q <= 8'h00;
      load_q   <= 1'b0;
    end else begin
      mode_q <= mode_q ^ press[2:0];
      load_q <= press[3];
      if (press[3])
        sw_out_q <= swq2_q;
    end
  end

  assign SW_OUT     = sw_out_q;
  assign KEY_OUT    = ~mode_q;
  assign MODE_LED   = mode_q;
  assign LOAD_PULSE = load_q;

endmodule

// File: tb/tb_calc_key_ctrl.sv
// tb_calc_key_ctrl: scoreboard bench for calc_key_ctrl with a
// sample-window reference model and randomized button activity.
module tb_calc_key_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] SW;
  logic [3:0] KEY;
  logic [7:0] SW_OUT;
  logic [2:0] KEY_OUT;
  logic       LOAD_PULSE;
  logic [2:0] MODE_LED;

  int checks   = 0;
  int failures = 0;

  calc_key_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (RESET),
    .SW        (SW),
    .KEY       (KEY),
    .SW_OUT    (SW_OUT),
    .KEY_OUT   (KEY_OUT),
    .LOAD_PULSE(LOAD_PULSE),
    .MODE_LED  (MODE_LED)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [3:0] khist [$];
  logic [7:0] swhist [$];
  logic [3:0] m_stable;
  logic [2:0] m_mode;
  logic [7:0] m_sw;
  bit         rst_chk;
  logic [7:0] lq [$];
  logic [2:0] mq [$];

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted at edge e when the D raw samples
  // taken at edges e-D-1 .. e-2 all differ from the accepted level
  // (samples before the last reset do not count).
  always @(posedge clk) begin
    if (RESET) begin
      khist.delete();
      swhist.delete();
      m_stable = 4'hF;
      m_mode   = 3'b000;
      m_sw     = 8'h00;
      lq.delete();
      mq.delete();
      rst_chk  = 1'b1;
    end else begin
      int  n;
      bit  ev;
      rst_chk = 1'b0;
      ev      = 1'b0;
      khist.push_back(KEY);
      swhist.push_back(SW);
      n = khist.size();
      if (n >= D + 2) begin
        for (int i = 0; i < 4; i++) begin
          bit diff;
          diff = 1'b1;
          for (int k = 2; k <= D + 1; k++)
            if (khist[n-1-k][i] == m_stable[i])
              diff = 1'b0;
          if (diff) begin
            m_stable[i] = ~m_stable[i];
            if (!m_stable[i]) begin
              if (i == 3) begin
                m_sw = swhist[n-3];
                lq.push_back(m_sw);
              end else begin
                m_mode[i] = ~m_mode[i];
                ev = 1'b1;
              end
            end
          end
        end
        void'(khist.pop_front());
        void'(swhist.pop_front());
      end
      if (ev)
        mq.push_back(~m_mode);
    end
  end

  // monitor: compares DUT outputs against queued expectations
  logic [2:0] last_ko;
  always @(negedge clk) begin
    if (rst_chk) begin
      check("rst_sw_out", SW_OUT, 8'h00);
      check("rst_key_out", KEY_OUT, 8'h07);
      check("rst_mode_led", MODE_LED, 8'h00);
      check("rst_load", LOAD_PULSE, 8'h00);
      last_ko = KEY_OUT;
    end else begin
      if (LOAD_PULSE) begin
        if (lq.size() == 0)
          check("load_unexpected", LOAD_PULSE, 8'h00);
        else
          check("load_value", SW_OUT, lq.pop_front());
      end else if (lq.size() != 0) begin
        check("load_missing", LOAD_PULSE, 8'h01);
        lq.delete();
      end
      if (KEY_OUT !== last_ko) begin
        if (mq.size() == 0)
          check("mode_unexpected", KEY_OUT, last_ko);
        else
          check("key_out", KEY_OUT, mq.pop_front());
      end else if (mq.size() != 0) begin
        check("mode_missing", KEY_OUT, mq.pop_front());
      end
      check("sw_out_hold", SW_OUT, m_sw);
      check("mode_led", MODE_LED, m_mode);
      last_ko = KEY_OUT;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    RESET = 1'b1;
    KEY   = 4'hF;
    SW    = 8'hA5;
    step(2);
    RESET = 1'b0;
    step(3);

    // load while held 20 cycles, then release
    SW = 8'h3D;
    step(3);
    KEY[3] = 1'b0;
    step(20);
    KEY[3] = 1'b1;
    SW = 8'h77;
    step(10);

    // bounce on KEY[0]
    begin
      logic [8:0] pat;
      pat = 9'b000000100;
      for (int i = 0; i < 9; i++) begin
        KEY[0] = pat[i];
        step(1);
      end
    end
    KEY[0] = 1'b1;
    step(10);

    // toggle abs twice
    for (int r = 0; r < 2; r++) begin
      KEY[1] = 1'b0;
      step(8);
      KEY[1] = 1'b1;
      step(8);
    end

    // simultaneous KEY[0] and KEY[2]
    KEY = 4'b1010;
    step(8);
    KEY = 4'hF;
    step(10);

    // reset in the middle of a load debounce
    SW = 8'hC4;
    KEY[3] = 1'b0;
    step(3);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    step(12);
    KEY[3] = 1'b1;
    step(10);

    // randomized button activity, switches and rare resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0)
          KEY[i] = ~KEY[i];
      SW    = 8'($urandom);
      RESET = ($urandom_range(199) == 0);
      step(1);
    end
    RESET = 1'b0;
    KEY   = 4'hF;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
